// File: rtl/hex_pkg.sv
// Shared definitions for the hex display scan driver: FSM states, digit count,
// blanked output levels and the active-low 7-segment glyph table.
// Latency: n/a (constants only). Backpressure: n/a.
package hex_pkg;

    typedef enum logic {
        ST_BLANK = 1'b0,
        ST_SHOW  = 1'b1
    } state_t;

    localparam int          NUM_DIGITS = 8;
    localparam logic [6:0]  SEG_OFF    = 7'h7F;
    localparam logic [7:0]  ANODE_OFF  = 8'hFF;

    // Active-low {g,f,e,d,c,b,a} glyphs; entry n is SEG_TABLE[n] (entry 0 is the last element).
    localparam logic [15:0][6:0] SEG_TABLE = {
        7'h0E, 7'h06, 7'h21, 7'h46,   // F E d C
        7'h03, 7'h08, 7'h10, 7'h00,   // b A 9 8
        7'h78, 7'h02, 7'h12, 7'h19,   // 7 6 5 4
        7'h30, 7'h24, 7'h79, 7'h40    // 3 2 1 0
    };

endpackage

// File: rtl/hex_seg_decode.sv
// Nibble to active-low 7-segment glyph lookup.
// Latency: combinational, zero cycles. Backpressure: none.
// Ports: nib (4-bit hex digit in), seg (7-bit {g,f,e,d,c,b,a} active-low out).
module hex_seg_decode
    import hex_pkg::*;
(
    input  logic [3:0] nib,
    output logic [6:0] seg
);

    assign seg = SEG_TABLE[nib];

endmodule

// File: rtl/hex_scan_driver.sv
// Time-multiplexes an 8-digit enable mask and 32-bit nibble bus onto a
// common-anode 7-segment board, one digit at a time with a blank gap between digits.
// Latency: outputs registered, one cycle after the FSM decides the next phase; no backpressure
// (inputs are snapshotted once per frame, changes at other times wait for the next frame).
// Ports: CLK, RST_N (sync active-low), MODE (digit enables), DISPLAY (nibbles),
//        ANODE (active-low digit select), SEG (active-low segments), FRAME_TICK (snapshot pulse).
// Optional: define HEX_LZS_EN for leading-zero suppression.
module hex_scan_driver
    import hex_pkg::*;
#(
    parameter int ON_CYCLES    = 50000,
    parameter int BLANK_CYCLES = 500
) (
    input  logic        CLK,
    input  logic        RST_N,
    input  logic [7:0]  MODE,
    input  logic [31:0] DISPLAY,
    output logic [7:0]  ANODE,
    output logic [6:0]  SEG,
    output logic        FRAME_TICK
);

    localparam int CNT_MAX = (ON_CYCLES > BLANK_CYCLES) ? ON_CYCLES : BLANK_CYCLES;
    localparam int CW      = (CNT_MAX > 1) ? $clog2(CNT_MAX) : 1;
    localparam int DW      = $clog2(NUM_DIGITS);

    state_t          state, nxt_state;
    logic [CW-1:0]   cnt, nxt_cnt;
    logic [DW-1:0]   dig, nxt_dig;
    logic [7:0]      snap_mode;
    logic [31:0]     snap_disp;

    logic            take_snap;
    logic [7:0]      eff_mode;
    logic [31:0]     eff_disp;
    logic [7:0]      eff_supp;
    logic [3:0]      nxt_nib;
    logic [6:0]      nxt_seg;
    logic            nxt_lit;

    // Snapshot edge is the first BLANK cycle of digit 0. The outputs for the
    // following phase may already need the new snapshot (BLANK_CYCLES == 1),
    // so the decode path looks through the snapshot registers on that edge.
    assign take_snap = (state == ST_BLANK) && (dig == '0) && (cnt == '0);
    assign eff_mode  = take_snap ? MODE    : snap_mode;
    assign eff_disp  = take_snap ? DISPLAY : snap_disp;

`ifdef HEX_LZS_EN
    logic [7:0] in_supp;
    logic [7:0] supp_mask;
    logic       zero_above;

    // Walk from the top digit down: a zero digit is dark while every enabled
    // digit above it is also zero. Digit 0 always shows.
    always_comb begin
        in_supp    = '0;
        zero_above = 1'b1;
        for (int d = NUM_DIGITS - 1; d >= 0; d--) begin
            in_supp[d] = (d != 0) && zero_above && (DISPLAY[4*d +: 4] == 4'h0);
            if (MODE[d] && (DISPLAY[4*d +: 4] != 4'h0)) begin
                zero_above = 1'b0;
            end
        end
    end

    always_ff @(posedge CLK) begin
        if (!RST_N) begin
            supp_mask <= '0;
        end else if (take_snap) begin
            supp_mask <= in_supp;
        end
    end

    assign eff_supp = take_snap ? in_supp : supp_mask;
`else
    assign eff_supp = '0;
`endif

    // Phase sequencing: BLANK_CYCLES dark, then ON_CYCLES lit, per digit.
    always_comb begin
        nxt_state = state;
        nxt_dig   = dig;
        nxt_cnt   = cnt + CW'(1);
        if ((state == ST_BLANK) && (cnt == CW'(BLANK_CYCLES - 1))) begin
            nxt_state = ST_SHOW;
            nxt_cnt   = '0;
        end else if ((state == ST_SHOW) && (cnt == CW'(ON_CYCLES - 1))) begin
            nxt_state = ST_BLANK;
            nxt_cnt   = '0;
            nxt_dig   = dig + DW'(1);
        end
    end

    assign nxt_nib = eff_disp[{nxt_dig, 2'b00} +: 4];
    assign nxt_lit = (nxt_state == ST_SHOW) && eff_mode[nxt_dig] && !eff_supp[nxt_dig];

    hex_seg_decode u_dec (
        .nib (nxt_nib),
        .seg (nxt_seg)
    );

    always_ff @(posedge CLK) begin
        if (!RST_N) begin
            state      <= ST_BLANK;
            cnt        <= '0;
            dig        <= '0;
            snap_mode  <= '0;
            snap_disp  <= '0;
            ANODE      <= ANODE_OFF;
            SEG        <= SEG_OFF;
            FRAME_TICK <= 1'b0;
        end else begin
            state      <= nxt_state;
            cnt        <= nxt_cnt;
            dig        <= nxt_dig;
            FRAME_TICK <= take_snap;
            if (take_snap) begin
                snap_mode <= MODE;
                snap_disp <= DISPLAY;
            end
            ANODE <= nxt_lit ? ~(8'b1 << nxt_dig) : ANODE_OFF;
            SEG   <= nxt_lit ? nxt_seg : SEG_OFF;
        end
    end

endmodule

// File: tb/tb_hex_scan_driver.sv
// Bench for hex_scan_driver with ON_CYCLES=4, BLANK_CYCLES=2 (48-cycle frame).
// A frame-position model predicts every output each cycle; directed literals pin it.
module tb_hex_scan_driver;

    localparam int ON    = 4;
    localparam int BL    = 2;
    localparam int SLOT  = ON + BL;
    localparam int FRAME = 8 * SLOT;

    logic        CLK = 1'b0;
    logic        RST_N = 1'b0;
    logic [7:0]  MODE = 8'h00;
    logic [31:0] DISPLAY = 32'h0;
    wire  [7:0]  ANODE;
    wire  [6:0]  SEG;
    wire         FRAME_TICK;

    int checks = 0;
    int errors = 0;

    hex_scan_driver #(.ON_CYCLES(ON), .BLANK_CYCLES(BL)) dut (
        .CLK        (CLK),
        .RST_N      (RST_N),
        .MODE       (MODE),
        .DISPLAY    (DISPLAY),
        .ANODE      (ANODE),
        .SEG        (SEG),
        .FRAME_TICK (FRAME_TICK)
    );

    always #5 CLK = ~CLK;

`ifdef HEX_LZS_EN
    localparam bit LZS = 1'b1;
`else
    localparam bit LZS = 1'b0;
`endif

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s actual=%h expected=%h at %0t", name, act, exp, $time);
        end
    endtask

    function automatic logic [6:0] seg_of(input logic [3:0] n);
        case (n)
            4'h0: return 7'h40;  4'h1: return 7'h79;  4'h2: return 7'h24;  4'h3: return 7'h30;
            4'h4: return 7'h19;  4'h5: return 7'h12;  4'h6: return 7'h02;  4'h7: return 7'h78;
            4'h8: return 7'h00;  4'h9: return 7'h10;  4'hA: return 7'h08;  4'hB: return 7'h03;
            4'hC: return 7'h46;  4'hD: return 7'h21;  4'hE: return 7'h06;  default: return 7'h0E;
        endcase
    endfunction

    // Dark when leading-zero suppression applies: above the highest enabled non-zero digit.
    function automatic bit suppressed(input int d, input logic [7:0] m, input logic [31:0] v);
        int h = 0;
        for (int e = 0; e < 8; e++) begin
            if (m[e] && (((v >> (4 * e)) & 32'hF) != 0)) h = e;
        end
        return LZS && (d > h);
    endfunction

    // Inputs as the DUT saw them on each rising edge.
    logic        cap_vld = 1'b0;
    logic        cap_rst;
    logic [7:0]  cap_mode;
    logic [31:0] cap_disp;
    always @(posedge CLK) begin
        cap_vld  <= 1'b1;
        cap_rst  <= RST_N;
        cap_mode <= MODE;
        cap_disp <= DISPLAY;
    end

    // Model: frame position counts edges since reset; snapshot taken when leaving position 0.
    int          pos = 0;
    logic [7:0]  m_mode = '0;
    logic [31:0] m_disp = '0;
    logic [7:0]  exp_an;
    logic [6:0]  exp_seg;
    logic        exp_tick;

    always @(negedge CLK) begin
        if (cap_vld) begin
            int d, off;
            if (!cap_rst) begin
                pos = 0;
                m_mode = '0;
                m_disp = '0;
                exp_an = 8'hFF; exp_seg = 7'h7F; exp_tick = 1'b0;
            end else begin
                if (pos == 0) begin
                    m_mode = cap_mode;
                    m_disp = cap_disp;
                end
                pos = (pos + 1) % FRAME;
                exp_tick = (pos == 1);
                d   = pos / SLOT;
                off = pos % SLOT;
                if (off >= BL && m_mode[d] && !suppressed(d, m_mode, m_disp)) begin
                    exp_an  = ~(8'h01 << d);
                    exp_seg = seg_of(4'((m_disp >> (4 * d)) & 32'hF));
                end else begin
                    exp_an = 8'hFF; exp_seg = 7'h7F;
                end
            end
            chk("anode", {24'h0, ANODE}, {24'h0, exp_an});
            chk("seg", {25'h0, SEG}, {25'h0, exp_seg});
            chk("tick", {31'h0, FRAME_TICK}, {31'h0, exp_tick});
        end
    end

    task automatic adv(input int n);
        repeat (n) @(negedge CLK);
    endtask

    // Leaves the bench at the cycle FRAME_TICK is high (frame position 1).
    task automatic wait_tick();
        int n = 0;
        @(negedge CLK);
        while (FRAME_TICK !== 1'b1 && n < 4 * FRAME) begin
            @(negedge CLK);
            n++;
        end
        chk("frame_tick_seen", {31'h0, FRAME_TICK}, 32'h1);
    endtask

    task automatic lit(input string name, input logic [7:0] an, input logic [6:0] sg);
        chk({name, "_anode"}, {24'h0, ANODE}, {24'h0, an});
        chk({name, "_seg"}, {25'h0, SEG}, {25'h0, sg});
    endtask

    initial begin
        // Reset held three cycles.
        MODE = 8'hFF; DISPLAY = 32'h76543210;
        adv(3);
        lit("reset", 8'hFF, 7'h7F);
        chk("reset_tick", {31'h0, FRAME_TICK}, 32'h0);
        RST_N = 1'b1;
        adv(1);
        chk("first_tick", {31'h0, FRAME_TICK}, 32'h1);
        lit("first_blank", 8'hFF, 7'h7F);
        adv(1);
        lit("dig0", 8'hFE, 7'h40);
        chk("tick_single", {31'h0, FRAME_TICK}, 32'h0);
        adv(42);
        lit("dig7", 8'h7F, 7'h78);
        adv(4);
        lit("wrap_blank", 8'hFF, 7'h7F);
        chk("tick_before_period", {31'h0, FRAME_TICK}, 32'h0);
        adv(1);
        chk("tick_period48", {31'h0, FRAME_TICK}, 32'h1);

        // Enable mask.
        MODE = 8'h0F; DISPLAY = 32'hFFFFABCD;
        wait_tick();
        adv(1);  lit("mask_dig0", 8'hFE, 7'h21);
        adv(18); lit("mask_dig3", 8'hF7, 7'h08);
        adv(12); lit("mask_dig5", 8'hFF, 7'h7F);

        // Mid-frame update must not tear.
        MODE = 8'hFF; DISPLAY = 32'h0;
        wait_tick();
        adv(19);
        DISPLAY = 32'h11111111;
        adv(12);
        if (LZS) lit("tear_old", 8'hFF, 7'h7F);
        else     lit("tear_old", 8'hDF, 7'h40);
        wait_tick();
        adv(31); lit("tear_new", 8'hDF, 7'h79);

        // Reset during digit 5 SHOW.
        RST_N = 1'b0;
        adv(1);
        lit("midreset", 8'hFF, 7'h7F);
        chk("midreset_tick", {31'h0, FRAME_TICK}, 32'h0);
        RST_N = 1'b1;
        adv(1);
        chk("restart_tick", {31'h0, FRAME_TICK}, 32'h1);
        adv(1);  lit("restart_dig0", 8'hFE, 7'h79);

        // Leading zeros.
        DISPLAY = 32'h00000100;
        wait_tick();
        adv(1);  lit("lz_dig0", 8'hFE, 7'h40);
        adv(6);  lit("lz_dig1", 8'hFD, 7'h40);
        adv(6);  lit("lz_dig2", 8'hFB, 7'h79);
        adv(6);
        if (LZS) lit("lz_dig3", 8'hFF, 7'h7F);
        else     lit("lz_dig3", 8'hF7, 7'h40);
        adv(24);
        if (LZS) lit("lz_dig7", 8'hFF, 7'h7F);
        else     lit("lz_dig7", 8'h7F, 7'h40);
        DISPLAY = 32'h0;
        wait_tick();
        adv(1);  lit("zero_dig0", 8'hFE, 7'h40);
        adv(6);
        if (LZS) lit("zero_dig1", 8'hFF, 7'h7F);
        else     lit("zero_dig1", 8'hFD, 7'h40);

        // Random traffic, occasional resets; the model checks every cycle.
        for (int i = 0; i < 3000; i++) begin
            @(negedge CLK);
            RST_N = ($urandom_range(0, 199) != 0);
            if ($urandom_range(0, 7) == 0) MODE = 8'($urandom);
            if ($urandom_range(0, 7) == 0) begin
                for (int k = 0; k < 8; k++)
                    DISPLAY[4*k +: 4] = ($urandom_range(0, 2) == 0) ? 4'($urandom) : 4'h0;
            end
        end
        RST_N = 1'b1;
        adv(2);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
